// File: rtl/apb_master_mux.sv
// ----------------------------------------------------------------------------
// apb_master_mux
//
// Single-outstanding APB master with address-decoded slave select.
// A request is taken over a valid/ready command port. It is then run as an
// APB SETUP + ACCESS transfer on the slave chosen by the top SEL_W address
// bits, and finished with a one-cycle response pulse that carries read data
// and an error flag.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN):
//   When defined, an ACCESS phase that waits TIMEOUT cycles without pready
//   is aborted and answered with an error. When undefined, ACCESS waits
//   indefinitely and TIMEOUT has no effect.
//
// Ports:
//   clk, preset          clock (rising edge), async active-low reset
//   req_valid/req_ready  command handshake
//   req_write            1 = write, 0 = read
//   req_addr             byte address, top SEL_W bits select the slave
//   req_wdata            write data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            read data (0 on writes and errors)
//   rsp_err              slave error, decode error or timeout
//   psel/penable/pwrite/paddr/pwdata   APB request side
//   prdata/pready/pslverr              per-slave APB return, slave i in
//                                      prdata[i*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
module apb_master_mux #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         preset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_wdata,
   output logic                         rsp_valid,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic [NUM_SLAVES-1:0]        psel,
   output logic                         penable,
   output logic                         pwrite,
   output logic [ADDR_W-1:0]            paddr,
   output logic [DATA_W-1:0]            pwdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]        pready,
   input  logic [NUM_SLAVES-1:0]        pslverr
);

   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [SEL_W-1:0]        idx_q, idx_d;

   logic [NUM_SLAVES-1:0]   psel_d;
   logic                    penable_d;
   logic                    pwrite_d;
   logic [ADDR_W-1:0]       paddr_d;
   logic [DATA_W-1:0]       pwdata_d;
   logic                    rsp_valid_d;
   logic [DATA_W-1:0]       rsp_rdata_d;
   logic                    rsp_err_d;
   logic                    req_ready_d;

   // Per-slave read data viewed as a packed array of words.
   logic [NUM_SLAVES-1:0][DATA_W-1:0] prdata_v;
   assign prdata_v = prdata;

   // Request decode. The compare is widened by one bit so that
   // NUM_SLAVES = 2**SEL_W still fits on the right-hand side.
   logic [SEL_W-1:0]        req_idx;
   logic                    idx_ok;
   logic [NUM_SLAVES-1:0]   req_onehot;

   assign req_idx = req_addr[ADDR_W-1 -: SEL_W];
   assign idx_ok  = ({1'b0, req_idx} < (SEL_W+1)'(NUM_SLAVES));

   always_comb begin
      req_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         req_onehot[i] = (req_idx == SEL_W'(i));
   end

   // Return mux: only the slave latched at accept time is observed.
   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_W-1:0]       sel_rdata;

   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            sel_ready = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata_v[i];
         end
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   // Counts ACCESS cycles that ended without pready. It holds k during the
   // (k+1)-th ACCESS cycle, so the limit is reached on ACCESS cycle TIMEOUT.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] wait_q, wait_d;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      psel_d      = psel;
      penable_d   = penable;
      pwrite_d    = pwrite;
      paddr_d     = paddr;
      pwdata_d    = pwdata;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_d      = wait_q;
`endif

      unique case (state_q)
         IDLE: begin
            // The registered req_ready gates acceptance, so nothing is taken
            // in the first cycle after reset is released.
            if (req_valid && req_ready) begin
               if (idx_ok) begin
                  state_d  = SETUP;
                  idx_d    = req_idx;
                  psel_d   = req_onehot;
                  paddr_d  = req_addr;
                  pwrite_d = req_write;
                  if (req_write)
                     pwdata_d = req_wdata;
               end else begin
                  // Decode error: answer at once, the APB bus stays quiet.
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end
            end
         end

         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_d    = '0;
`endif
         end

         ACCESS: begin
            if (sel_ready) begin
               state_d     = IDLE;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = sel_err;
               rsp_rdata_d = (!pwrite && !sel_err) ? sel_rdata : '0;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = IDLE;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
`endif
         end

         default: begin
            state_d   = IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
         end
      endcase

      // Ready tracks the state being entered, so it reasserts in the same
      // cycle that rsp_valid pulses.
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge preset) begin
      if (!preset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         psel      <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         req_ready <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         psel      <= psel_d;
         penable   <= penable_d;
         pwrite    <= pwrite_d;
         paddr     <= paddr_d;
         pwdata    <= pwdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         req_ready <= req_ready_d;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_q    <= wait_d;
`endif
      end
   end

endmodule

// File: tb/tb_apb_master_mux.sv
// ----------------------------------------------------------------------------
// tb_apb_master_mux
//
// Bench for apb_master_mux. Instance dut has four slaves. Instance dut3 has
// three slaves, so that slave index 3 is a decode error. Both share clock,
// reset and request fields.
// The bench acts as the APB slave. The selected slave holds pready low for a
// chosen number of ACCESS cycles. Unselected slaves toggle pready, pslverr
// and prdata at random.
// Expected values come from the transfer rules:
//   latency = SETUP + (waits + 1) ACCESS cycles + response cycle
//   rdata   = read && !err ? slave data : 0
//   pwdata  = last written data, held across reads
// ----------------------------------------------------------------------------
module tb_apb_master_mux;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 32;
   localparam int NS      = 4;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  preset;
   logic                  req_valid, req_ready, req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid, rsp_err;
   logic [DATA_W-1:0]     rsp_rdata;
   logic [NS-1:0]         psel;
   logic                  penable, pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [NS*DATA_W-1:0]  prdata;
   logic [NS-1:0]         pready, pslverr;

   logic                  dec_valid, dec_ready, dec_rsp_valid, dec_rsp_err;
   logic [DATA_W-1:0]     dec_rsp_rdata, dec_pwdata;
   logic [2:0]            dec_psel;
   logic                  dec_penable, dec_pwrite;
   logic [ADDR_W-1:0]     dec_paddr;

   int                    checks;
   int                    fails;
   logic [DATA_W-1:0]     last_wdata;   // reference model of pwdata

   always #5 clk = ~clk;

   apb_master_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .preset(preset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   apb_master_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(3), .TIMEOUT(TIMEOUT)) dut3 (
      .clk(clk), .preset(preset),
      .req_valid(dec_valid), .req_ready(dec_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(dec_rsp_valid), .rsp_rdata(dec_rsp_rdata), .rsp_err(dec_rsp_err),
      .psel(dec_psel), .penable(dec_penable), .pwrite(dec_pwrite), .paddr(dec_paddr),
      .pwdata(dec_pwdata),
      .prdata(prdata[3*DATA_W-1:0]), .pready(pready[2:0]), .pslverr(pslverr[2:0])
   );

   // Issues one request on dut and plays the selected slave. The selected
   // slave raises pready on ACCESS cycle waits+1.
   // Reports the response cycle (1-based after the accept edge) and the data.
   // It also reports the ACCESS cycle count and whether the bus stayed
   // consistent while busy.
   task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input int waits, input logic err, input logic [31:0] rd,
                           output int lat, output logic [31:0] o_rdata, output logic o_err,
                           output int acc, output logic bus_ok);
      int idx, guard;
      logic [NS-1:0] exp_psel;
      logic [31:0]   exp_pwdata;
      idx        = int'(addr[7:6]);
      exp_psel   = 4'b0001 << idx;
      exp_pwdata = wr ? wd : last_wdata;
      bus_ok = 1'b1; lat = 0; acc = 0; o_rdata = '0; o_err = 1'b0;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      pready = '0; pslverr = '0;
      for (int s = 0; s < NS; s++) prdata[s*DATA_W +: DATA_W] = (s == idx) ? rd : $urandom;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (rsp_valid === 1'b1) begin
            lat = cyc; o_rdata = rsp_rdata; o_err = rsp_err;
            if (psel !== '0 || penable !== 1'b0 || req_ready !== 1'b1) bus_ok = 1'b0;
            break;
         end
         if (cyc == 1 && penable !== 1'b0) bus_ok = 1'b0;
         if (cyc > 1 && penable !== 1'b1) bus_ok = 1'b0;
         if (psel !== exp_psel || paddr !== addr || pwrite !== wr ||
             pwdata !== exp_pwdata || req_ready !== 1'b0) bus_ok = 1'b0;
         if (penable === 1'b1) acc++;
         // New requests while busy must be ignored.
         req_valid = (req_ready === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
         req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
         pready  = 4'($urandom);
         pslverr = 4'($urandom);
         pready[idx]  = (penable === 1'b1) && (acc > waits);
         pslverr[idx] = pready[idx] ? err : 1'($urandom);
         for (int s = 0; s < NS; s++) prdata[s*DATA_W +: DATA_W] = (s == idx) ? rd : $urandom;
         @(posedge clk); #1;
      end
      req_valid = 1'b0; pready = '0; pslverr = '0;
      if (wr) last_wdata = wd;
   endtask

   task automatic test_reset();
      preset = 1'b0; req_valid = 1'b0; dec_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; prdata = '0; pready = '0; pslverr = '0;
      last_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (psel !== '0 || penable !== 1'b0) begin
         fails++; $display("FAIL reset_ctrl: psel=%b penable=%b, expected 0000/0", psel, penable);
      end
      checks++;
      if ({pwrite, paddr, pwdata} !== '0) begin
         fails++; $display("FAIL reset_bus: pwrite=%b paddr=%h pwdata=%h, expected 0", pwrite, paddr, pwdata);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
         fails++; $display("FAIL reset_rsp: v=%b e=%b d=%h, expected 0", rsp_valid, rsp_err, rsp_rdata);
      end
      checks++;
      if (req_ready !== 1'b0) begin
         fails++; $display("FAIL reset_ready: req_ready=%b, expected 0", req_ready);
      end
      @(negedge clk); preset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || psel !== '0 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL reset_release: ready=%b psel=%b rsp_valid=%b, expected 1/0000/0",
                           req_ready, psel, rsp_valid);
      end
   endtask

   task automatic test_write();
      int lat, acc; logic [31:0] d; logic e, ok;
      run_xfer(1'b1, 8'h45, 32'hDEADBEEF, 0, 1'b0, $urandom, lat, d, e, acc, ok);
      checks++;
      if (lat != 3 || acc != 1) begin
         fails++; $display("FAIL write_latency: lat=%0d access=%0d, expected 3/1", lat, acc);
      end
      checks++;
      if (e !== 1'b0 || d !== 32'h0) begin
         fails++; $display("FAIL write_rsp: err=%b rdata=%h, expected 0/0", e, d);
      end
      checks++;
      if (ok !== 1'b1) begin
         fails++; $display("FAIL write_bus: bus_ok=%b, expected 1 (psel 0010, addr 45)", ok);
      end
   endtask

   task automatic test_read_wait();
      int lat, acc; logic [31:0] d; logic e, ok;
      run_xfer(1'b0, 8'hC0, $urandom, 3, 1'b0, 32'h12345678, lat, d, e, acc, ok);
      checks++;
      if (lat != 6 || acc != 4) begin
         fails++; $display("FAIL read_wait_latency: lat=%0d access=%0d, expected 6/4", lat, acc);
      end
      checks++;
      if (e !== 1'b0 || d !== 32'h12345678) begin
         fails++; $display("FAIL read_wait_rsp: err=%b rdata=%h, expected 0/12345678", e, d);
      end
      checks++;
      if (ok !== 1'b1) begin
         fails++; $display("FAIL read_wait_bus: bus_ok=%b, expected 1 (pwdata held at DEADBEEF)", ok);
      end
   endtask

   task automatic test_slave_err();
      int lat, acc; logic [31:0] d; logic e, ok;
      run_xfer(1'b0, 8'h80, $urandom, 1, 1'b1, 32'hCAFEF00D, lat, d, e, acc, ok);
      checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat != 4) begin
         fails++; $display("FAIL slave_err: err=%b rdata=%h lat=%0d, expected 1/0/4", e, d, lat);
      end
      checks++;
      if (ok !== 1'b1) begin
         fails++; $display("FAIL slave_err_bus: bus_ok=%b, expected 1", ok);
      end
   endtask

   task automatic test_decode_error();
      int lat, seen; logic [31:0] d;
      // A good read on slave 2 first, so the response register holds non-zero data.
      dec_valid = 1'b1; req_write = 1'b0; req_addr = 8'h80; req_wdata = $urandom;
      pready = 4'b0100; pslverr = '0; prdata[2*DATA_W +: DATA_W] = 32'hA5A50F0F;
      @(posedge clk); #1; dec_valid = 1'b0;
      lat = 0; d = '0;
      for (int c = 1; c <= 10; c++) begin
         if (dec_rsp_valid === 1'b1) begin lat = c; d = dec_rsp_rdata; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (lat != 3 || d !== 32'hA5A50F0F) begin
         fails++; $display("FAIL dec_good_read: lat=%0d rdata=%h, expected 3/a5a50f0f", lat, d);
      end
      dec_valid = 1'b1; req_addr = 8'hC0 | 8'($urandom_range(0, 63)); pready = '1;
      @(posedge clk); #1; dec_valid = 1'b0;
      checks++;
      if (dec_rsp_valid !== 1'b1 || dec_rsp_err !== 1'b1 || dec_rsp_rdata !== '0) begin
         fails++; $display("FAIL dec_err_rsp: v=%b e=%b d=%h, expected 1/1/0",
                           dec_rsp_valid, dec_rsp_err, dec_rsp_rdata);
      end
      checks++;
      if (dec_psel !== '0 || dec_ready !== 1'b1) begin
         fails++; $display("FAIL dec_err_idle: psel=%b ready=%b, expected 000/1", dec_psel, dec_ready);
      end
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (dec_psel !== '0 || dec_penable !== 1'b0 || dec_rsp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         fails++; $display("FAIL dec_err_quiet: activity cycles=%0d, expected 0", seen);
      end
      pready = '0;
   endtask

   task automatic test_reset_mid_access();
      int lat, acc, seen; logic [31:0] d, rd; logic e, ok;
      while (req_ready !== 1'b1) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40 | 8'($urandom_range(0, 63));
      req_wdata = $urandom; pready = '0; pslverr = '0;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (psel !== 4'b0010 || penable !== 1'b1) begin
         fails++; $display("FAIL mid_precond: psel=%b penable=%b, expected 0010/1", psel, penable);
      end
      #2 preset = 1'b0;
      #1;
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata, req_ready} !== '0) begin
         fails++; $display("FAIL mid_reset_async: psel=%b en=%b pwdata=%h rsp_valid=%b, expected all 0",
                           psel, penable, pwdata, rsp_valid);
      end
      pready = '1;
      seen = 0;
      repeat (2) begin @(posedge clk); #1; if (rsp_valid !== 1'b0 || psel !== '0) seen++; end
      @(negedge clk); preset = 1'b1; pready = '0;
      repeat (4) begin @(posedge clk); #1; if (rsp_valid !== 1'b0 || psel !== '0) seen++; end
      checks++;
      if (seen != 0) begin
         fails++; $display("FAIL mid_no_rsp: stray cycles=%0d, expected 0", seen);
      end
      last_wdata = '0;
      rd = $urandom;
      run_xfer(1'b0, 8'($urandom_range(0, 63)), $urandom, 2, 1'b0, rd, lat, d, e, acc, ok);
      checks++;
      if (lat != 5 || d !== rd || e !== 1'b0 || ok !== 1'b1) begin
         fails++; $display("FAIL mid_recover: lat=%0d rdata=%h err=%b bus_ok=%b, expected 5/%h/0/1",
                           lat, d, e, ok, rd);
      end
   endtask

   task automatic test_wait_limit();
      int lat, acc; logic [31:0] d, rd; logic e, ok;
      rd = $urandom;
`ifdef APB_MASTER_TIMEOUT_EN
      run_xfer(1'b0, 8'h10, $urandom, 1000, 1'b0, rd, lat, d, e, acc, ok);
      checks++;
      if (lat != TIMEOUT + 2 || acc != TIMEOUT || e !== 1'b1 || d !== '0 || ok !== 1'b1) begin
         fails++; $display("FAIL timeout_abort: lat=%0d acc=%0d err=%b rdata=%h ok=%b, expected %0d/%0d/1/0/1",
                           lat, acc, e, d, ok, TIMEOUT + 2, TIMEOUT);
      end
      run_xfer(1'b0, 8'h90, $urandom, TIMEOUT - 1, 1'b0, rd, lat, d, e, acc, ok);
      checks++;
      if (lat != TIMEOUT + 2 || acc != TIMEOUT || e !== 1'b0 || d !== rd || ok !== 1'b1) begin
         fails++; $display("FAIL timeout_edge: lat=%0d acc=%0d err=%b rdata=%h ok=%b, expected %0d/%0d/0/%h/1",
                           lat, acc, e, d, ok, TIMEOUT + 2, TIMEOUT, rd);
      end
`else
      run_xfer(1'b0, 8'hD0, $urandom, 40, 1'b0, rd, lat, d, e, acc, ok);
      checks++;
      if (lat != 43 || acc != 41 || e !== 1'b0 || d !== rd || ok !== 1'b1) begin
         fails++; $display("FAIL long_wait: lat=%0d acc=%0d err=%b rdata=%h ok=%b, expected 43/41/0/%h/1",
                           lat, acc, e, d, ok, rd);
      end
`endif
   endtask

   task automatic test_random();
      int lat, acc, waits, gap, stray; logic [31:0] d, rd, wd; logic e, ok, wr, err;
      logic [7:0] addr;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom); addr = 8'($urandom); wd = $urandom; rd = $urandom;
         waits = $urandom_range(0, 4); err = ($urandom_range(0, 3) == 0);
         run_xfer(wr, addr, wd, waits, err, rd, lat, d, e, acc, ok);
         checks++;
         if (lat != 3 + waits || acc != waits + 1) begin
            fails++; $display("FAIL rand_latency[%0d]: lat=%0d acc=%0d, expected %0d/%0d",
                              n, lat, acc, 3 + waits, waits + 1);
         end
         checks++;
         if (e !== err || d !== ((!wr && !err) ? rd : 32'h0)) begin
            fails++; $display("FAIL rand_rsp[%0d]: err=%b rdata=%h, expected %b/%h",
                              n, e, d, err, (!wr && !err) ? rd : 32'h0);
         end
         checks++;
         if (ok !== 1'b1) begin
            fails++; $display("FAIL rand_bus[%0d]: bus_ok=%b, expected 1", n, ok);
         end
         // Optional idle gap, which must stay silent. A zero gap makes the
         // next request go out in the response cycle.
         gap = $urandom_range(0, 2); stray = 0;
         repeat (gap) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || psel !== '0) stray++;
         end
         checks++;
         if (stray != 0) begin
            fails++; $display("FAIL rand_idle[%0d]: stray cycles=%0d, expected 0", n, stray);
         end
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_write();
      test_read_wait();
      test_slave_err();
      test_decode_error();
      test_reset_mid_access();
      test_wait_limit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised APB master. Accepts single read/write requests over a valid/ready command port and runs standard APB IDLE/SETUP/ACCESS transfers.
- Decodes the upper address bits to one of NUM_SLAVES select lines, with per-slave PREADY/PSLVERR/PRDATA return muxing.
- Returns one response per request: data plus error flag.
- Sits between the bus bridge/CPU-side logic and the peripheral slaves.

Parameters:
- ADDR_W, 8, request/paddr width in bits.
- DATA_W, 32, pwdata/prdata width in bits.
- NUM_SLAVES, 4, number of psel lines (1..16). SEL_W = max(1, clog2(NUM_SLAVES)).
- TIMEOUT, 16, max ACCESS cycles before forced error (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- preset  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; [ADDR_W-1 -: SEL_W] is the slave index.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse, response available.
- rsp_rdata  out  DATA_W  read data; 0 on writes and on errors.
- rsp_err  out  1  qualified by rsp_valid: PSLVERR, decode error, or timeout.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NUM_SLAVES*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W].
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (preset=0, asynchronous): state=IDLE. psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
- All outputs are registered. No combinational path from any input to any output.

States:
- IDLE: req_ready=1.
  - On accept with a valid slave index: latch addr/wdata/write into paddr/pwdata/pwrite, set psel[idx]=1, go to SETUP.
  - pwdata is updated only on write requests; it holds its previous value on reads.
  - Slave index >= NUM_SLAVES (decode error): no APB activity. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0. Stay IDLE.
- SETUP: penable=0 for exactly one cycle, then go to ACCESS with penable=1. req_ready=0.
- ACCESS: hold psel/paddr/pwrite/pwdata/penable stable while pready[idx]=0.
  - On pready[idx]=1: capture rsp_err=pslverr[idx] and rsp_rdata = (!pwrite && !pslverr[idx]) ? prdata[idx] : 0.
  - Pulse rsp_valid next cycle. Drop penable and psel, return to IDLE.
- Only the selected slave's pready/pslverr/prdata are observed; other slaves' signals are ignored.

Throughput and latency:
- No back-to-back pipelining: req_ready reasserts in the cycle rsp_valid pulses.
- Minimum latency from accept to rsp_valid is 3 cycles (SETUP, ACCESS with pready=1, response). Each wait state adds 1.
- req_valid deasserting while not ready is legal; no request is lost or duplicated.
- Reset asserted mid-transfer aborts immediately. No response is generated for the aborted request.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready[idx]=0.
  - When it reaches TIMEOUT-1 with pready still low: abort the transfer (psel/penable low), return rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - pready arriving on the same cycle as the limit takes priority: normal completion.
- Not defined: no counter logic. ACCESS waits indefinitely for pready. TIMEOUT is unused.

Test Plan:
- Write: req_addr=0x45 (slave 1), wdata=0xDEADBEEF, pready[1]=1 immediately -> psel=4'b0010; SETUP then ACCESS cycle with penable=1; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0xC0 (slave 3), prdata[3]=0x12345678 -> paddr/psel stable for 4 ACCESS cycles; rsp_rdata=0x12345678, latency 6 cycles.
- Slave error: read slave 2 with pslverr[2]=1 on the ready cycle -> rsp_err=1, rsp_rdata=0.
- Decode error: NUM_SLAVES=3, addr=0xC0 -> psel never asserts; rsp_valid+rsp_err one cycle after accept.
- Reset mid-ACCESS: drop preset during a wait state -> all outputs 0 immediately, no rsp_valid; the next request completes normally.
- Timeout (macro defined, TIMEOUT=16): pready held low -> after 16 ACCESS cycles psel/penable drop and rsp_err=1. With pready rising on cycle 16 -> normal completion, rsp_err=0.
